wb_shared_bus_arbiter: RTL

Shared-bus Wishbone B4 (classic, single-cycle handshakes) interconnect between the two processor masters (instruction bus, master 0; data bus, master 1) and the system slaves (boot ROM, RAM, LED, I2C0).

- Arbitrates round-robin for bus ownership, held for a whole `cyc` tenure.
- Decodes the owner's address to one slave and routes the handshake back.
- Terminates accesses to unmapped addresses, and optionally stalled accesses, with `err`.
- Sits between the processor bus ports and the slave bus ports, clocked from the same system clock/reset distribution.

---
 rtl/wb_bus_pkg.sv | 26 ++
 rtl/wb_shared_bus_arbiter_rr.sv | 26 ++
 rtl/wb_shared_bus_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect:
// default widths, the slave address map and the arbiter state type.
package wb_bus_pkg;

  localparam int WB_ADDR_W  = 32;
  localparam int WB_DATA_W  = 32;
  localparam int WB_NSLAVES = 4;

  // Slave order: 0 boot ROM, 1 RAM, 2 LED, 3 I2C0
  localparam logic [WB_ADDR_W-1:0] SLAVE_BASE [WB_NSLAVES] = '{
    32'h0000_0000, 32'h1000_0000, 32'h8000_0000, 32'h8000_0100
  };
  localparam logic [WB_ADDR_W-1:0] SLAVE_MASK [WB_NSLAVES] = '{
    32'hFFFF_C000, 32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFE0
  };

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    DECERR
`ifdef WB_ARB_TIMEOUT_EN
    , TOERR
`endif
  } arb_state_t;

endpackage

// File: rtl/wb_shared_bus_arbiter_rr.sv
// Two-requester round-robin grant register for the shared Wishbone bus.
// A grant, once taken, is held until release_bus; the last owner then loses ties.
module wb_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       release_bus,
  output logic [1:0] grant
);

  logic last_grant;  // 1 = master 1 owned the bus most recently

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant      <= 2'b00;
      last_grant <= 1'b1;
    end else if (grant == 2'b00) begin
      if (req == 2'b11) grant <= last_grant ? 2'b01 : 2'b10;
      else              grant <= req;
    end else if (release_bus) begin
      last_grant <= grant[1];
      grant      <= 2'b00;
    end
  end

endmodule

// File: rtl/wb_shared_bus_arbiter.sv
// Shared-bus Wishbone B4 classic interconnect: two masters, NSLAVES slaves.
// Define WB_ARB_TIMEOUT_EN to terminate stalled accesses with err after TIMEOUT_CYCLES.
module wb_shared_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int NSLAVES        = WB_NSLAVES,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      m_cyc_i,
  input  logic [1:0]                      m_stb_i,
  input  logic [1:0]                      m_we_i,
  input  logic [1:0][ADDR_W-1:0]          m_adr_i,
  input  logic [1:0][DATA_W-1:0]          m_dat_i,
  input  logic [1:0][DATA_W/8-1:0]        m_sel_i,
  output logic [DATA_W-1:0]               m_dat_o,
  output logic [1:0]                      m_ack_o,
  output logic [1:0]                      m_err_o,
  output logic [1:0]                      m_rty_o,
  output logic [NSLAVES-1:0]              s_cyc_o,
  output logic [NSLAVES-1:0]              s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_W-1:0]               s_adr_o,
  output logic [DATA_W-1:0]               s_dat_o,
  output logic [DATA_W/8-1:0]             s_sel_o,
  input  logic [NSLAVES-1:0][DATA_W-1:0]  s_dat_i,
  input  logic [NSLAVES-1:0]              s_ack_i,
  input  logic [NSLAVES-1:0]              s_err_i,
  input  logic [NSLAVES-1:0]              s_rty_i,
  output logic [1:0]                      grant_o
);

  arb_state_t          state, state_nx;
  logic [1:0]          grant;
  logic                owner;
  logic                owned;
  logic                release_bus;
  logic [NSLAVES-1:0]  hit;
  logic                slv_ack, slv_err, slv_rty;
  logic [DATA_W-1:0]   slv_dat;

  wb_rr_arbiter u_rr (
    .clock       (clock),
    .reset       (reset),
    .req         (m_cyc_i),
    .release_bus (release_bus),
    .grant       (grant)
  );

  assign owner       = grant[1];
  assign owned       = |grant;
  assign grant_o     = grant;
  assign release_bus = (state == OWNED) && !m_cyc_i[owner];

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i[owner] & ADDR_W'(SLAVE_MASK[i])) == ADDR_W'(SLAVE_BASE[i])) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slv_ack = 1'b0;
    slv_err = 1'b0;
    slv_rty = 1'b0;
    slv_dat = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (hit[i]) begin
        slv_ack = s_ack_i[i];
        slv_err = s_err_i[i];
        slv_rty = s_rty_i[i];
        slv_dat = s_dat_i[i];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        stall;

  assign stall = (state == OWNED) && m_cyc_i[owner] && m_stb_i[owner] && (hit != '0)
                 && !(slv_ack || slv_err || slv_rty);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                              to_cnt <= '0;
    else if (stall && (state_nx == OWNED))   to_cnt <= to_cnt + 16'd1;
    else                                     to_cnt <= '0;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_cyc_o  = '0;
    s_stb_o  = '0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m_dat_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;

    if (owned) begin
      s_we_o  = m_we_i[owner];
      s_adr_o = m_adr_i[owner];
      s_dat_o = m_dat_i[owner];
      s_sel_o = m_sel_i[owner];
      m_dat_o = slv_dat;
    end

    case (state)
      IDLE: if (m_cyc_i != 2'b00) state_nx = OWNED;
      OWNED: begin
        s_cyc_o        = hit & {NSLAVES{m_cyc_i[owner]}};
        s_stb_o        = hit & {NSLAVES{m_stb_i[owner]}};
        m_ack_o[owner] = slv_ack;
        m_err_o[owner] = slv_err;
        m_rty_o[owner] = slv_rty;
        if (!m_cyc_i[owner])                      state_nx = IDLE;
        else if (m_stb_i[owner] && (hit == '0))   state_nx = DECERR;
`ifdef WB_ARB_TIMEOUT_EN
        else if (stall && (to_cnt == 16'(TIMEOUT_CYCLES - 1))) state_nx = TOERR;
`endif
      end
      DECERR: begin
        m_err_o[owner] = 1'b1;
        state_nx       = OWNED;
      end
`ifdef WB_ARB_TIMEOUT_EN
      TOERR: begin
        m_err_o[owner] = 1'b1;
        state_nx       = OWNED;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule
